// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - length-prefixed stream loader that fills instruction memory and holds the core in reset
// Optional trailer checksum: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_SIZE   = 1024,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  cpu_rst,
  output logic                  done,
  output logic                  error
);

  localparam int CW = $clog2(MEM_SIZE + 1);
  localparam logic [DATA_WIDTH-1:0] MAX_N = DATA_WIDTH'(MEM_SIZE - BASE_ADDR);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_LEN, S_LOAD, S_CHK, S_FLUSH, S_DONE, S_ERR} state_t;
`else
  typedef enum logic [2:0] {S_LEN, S_LOAD, S_FLUSH, S_DONE, S_ERR} state_t;
`endif

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         len_q, len_d;
  logic                  ready_q, ready_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  xfer;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
`endif

  assign xfer = in_valid && ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    unique case (state_q)
      S_LEN: begin
        if (xfer) begin
          cnt_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d = '0;
`endif
          // Full-width compare so oversized headers cannot alias into range.
          if (in_data == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_FLUSH;
`endif
          end else if (in_data > MAX_N) begin
            state_d = S_ERR;
          end else begin
            state_d = S_LOAD;
            len_d   = in_data[CW-1:0];
          end
        end
      end
      S_LOAD: begin
        if (xfer) begin
          we_d   = 1'b1;
          addr_d = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(cnt_q);
          data_d = in_data;
          cnt_d  = cnt_q + CW'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d  = sum_q + in_data;
`endif
          if (cnt_q == len_q - CW'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_FLUSH;
`endif
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (xfer) state_d = (in_data == sum_q) ? S_FLUSH : S_ERR;
      end
`endif
      S_FLUSH: state_d = S_DONE;
      default: state_d = state_q;
    endcase
`ifdef IMEM_LOADER_CHECKSUM_EN
    ready_d = (state_d == S_LEN) || (state_d == S_LOAD) || (state_d == S_CHK);
`else
    ready_d = (state_d == S_LEN) || (state_d == S_LOAD);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LEN;
      cnt_q   <= '0;
      len_q   <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign in_ready         = ready_q;
  assign mem_write_enable = we_q;
  assign mem_write_addr   = addr_q;
  assign mem_write_data   = data_q;
  assign done             = (state_q == S_DONE);
  assign error            = (state_q == S_ERR);
  assign cpu_rst          = (state_q != S_DONE);

endmodule
